// File: rtl/hazard_pkg.sv
// Shared types and constants for the load-use hazard controller.
//   ZERO_REG     : architectural zero register, never a hazard source
//   MAX_LOAD_LAT : deepest supported load latency (scoreboard depth)
//   MAX_AW       : widest register address the scoreboard entry can hold
//   sb_entry_t   : one scoreboard slot {valid, dst}
//   mode_t       : resolved pipeline control mode for the current cycle
package hazard_pkg;

  localparam int ZERO_REG     = 0;
  localparam int MAX_LOAD_LAT = 4;
  localparam int MAX_AW       = 8;

  // dst is sized for MAX_AW; narrower register files zero-extend into it.
  typedef struct packed {
    logic              valid;
    logic [MAX_AW-1:0] dst;
  } sb_entry_t;

  typedef enum logic [1:0] {
    NORMAL,
    STALL,
    FLUSH,
    FREEZE
  } mode_t;

endpackage

// File: rtl/load_scoreboard.sv
// Shift array of in-flight loads whose results are not yet visible to ID.
// Entry k holds a load issued k+1 cycles ago; the last entry retires on shift.
// Ports:
//   clock, reset         : rising-edge clock, async active-high reset
//   shift_en             : advance the array by one slot
//   ins_valid, ins_dst   : entry pushed into slot 0 on a shift
//   rs, rt               : ID source addresses to compare
//   match_rs, match_rt   : per-entry hits (valid && dst == address)
module load_scoreboard
  import hazard_pkg::*;
#(
  parameter int AW    = 5,
  parameter int DEPTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             ins_valid,
  input  logic [AW-1:0]    ins_dst,
  input  logic [AW-1:0]    rs,
  input  logic [AW-1:0]    rt,
  output logic [DEPTH-1:0] match_rs,
  output logic [DEPTH-1:0] match_rt
);

  sb_entry_t sb [DEPTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) sb[k] <= '0;
    end else if (shift_en) begin
      sb[0].valid <= ins_valid;
      sb[0].dst   <= MAX_AW'(ins_dst);
      for (int k = 1; k < DEPTH; k++) sb[k] <= sb[k-1];
    end
  end

  always_comb begin
    match_rs = '0;
    match_rt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      match_rs[k] = sb[k].valid && (sb[k].dst == MAX_AW'(rs));
      match_rt[k] = sb[k].valid && (sb[k].dst == MAX_AW'(rt));
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Load-use hazard, branch flush and memory freeze control for a 5-stage pipe.
// Ports:
//   clock, reset                 : rising-edge clock, async active-high reset
//   id_*                         : decoded fields of the instruction in ID
//   br_taken                     : branch resolved taken this cycle
//   mem_busy                     : data memory not ready, freeze everything
//   pc_write, ifid_write         : PC / IF-ID write enables
//   ifid_flush, idex_bubble      : squash IF-ID, inject zero control into ID-EX
//   stall_count                  : saturating count of load-use stall cycles
//
// mode   | meaning
// NORMAL | advance; ID load (if any) enters the scoreboard
// STALL  | hold PC/IF-ID, bubble into EX, count the cycle
// FLUSH  | squash IF-ID and ID; redirect PC
// FREEZE | hold everything, scoreboard and counter included
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int AW       = 5,
  parameter int LOAD_LAT = 1,
  parameter int CW       = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_uses_rs,
  input  logic          id_uses_rt,
  input  logic [AW-1:0] id_dst,
  input  logic          id_memread,
  input  logic          id_regwrite,
  input  logic          br_taken,
  input  logic          mem_busy,
  output logic          pc_write,
  output logic          ifid_write,
  output logic          ifid_flush,
  output logic          idex_bubble,
  output logic [CW-1:0] stall_count
);

  if (LOAD_LAT < 1 || LOAD_LAT > MAX_LOAD_LAT) begin : g_bad_load_lat
    $error("pipe_hazard_ctrl: LOAD_LAT=%0d outside 1..%0d", LOAD_LAT, MAX_LOAD_LAT);
  end
  if (AW < 1 || AW > MAX_AW) begin : g_bad_aw
    $error("pipe_hazard_ctrl: AW=%0d outside 1..%0d", AW, MAX_AW);
  end

  logic [LOAD_LAT-1:0] match_rs;
  logic [LOAD_LAT-1:0] match_rt;
  logic                hazard;
  logic                issuing_load;
  logic                ins_valid;
  mode_t               mode;

  assign issuing_load = id_valid && id_memread && id_regwrite && (id_dst != AW'(ZERO_REG));

  assign hazard = id_valid &&
                  ((id_uses_rs && (id_rs != AW'(ZERO_REG)) && (|match_rs)) ||
                   (id_uses_rt && (id_rt != AW'(ZERO_REG)) && (|match_rt)));

  // Only a load that actually advances out of ID becomes pending; a stalled
  // load is re-presented next cycle and a flushed one never executes.
  assign ins_valid = (mode == NORMAL) && issuing_load;

  load_scoreboard #(
    .AW    (AW),
    .DEPTH (LOAD_LAT)
  ) u_sb (
    .clock     (clock),
    .reset     (reset),
    .shift_en  (mode != FREEZE),
    .ins_valid (ins_valid),
    .ins_dst   (ins_valid ? id_dst : '0),
    .rs        (id_rs),
    .rt        (id_rt),
    .match_rs  (match_rs),
    .match_rt  (match_rt)
  );

  always_comb begin
    if (mem_busy)      mode = FREEZE;
    else if (br_taken) mode = FLUSH;
    else if (hazard)   mode = STALL;
    else               mode = NORMAL;
  end

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else begin
      case (mode)
        FREEZE: begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
        end
        FLUSH: begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end
        STALL: begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      stall_count <= '0;
    else if ((mode == STALL) && (stall_count != '1))
      stall_count <= stall_count + CW'(1);
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  AW        5   register-address width
  LOAD_LAT  1   cycles a load result is unavailable to an ID consumer; legal 1..4
  CW        16  stall-counter width
REQ-002 Ports (name  direction  width  meaning), one per line:
  clock        in   1   single clock, rising edge
  reset        in   1   asynchronous, active-high
  id_valid     in   1   ID holds a real instruction
  id_rs        in   AW  ID source register 1
  id_rt        in   AW  ID source register 2
  id_uses_rs   in   1   instruction reads id_rs
  id_uses_rt   in   1   instruction reads id_rt
  id_dst       in   AW  ID destination register
  id_memread   in   1   ID instruction is a load
  id_regwrite  in   1   ID instruction writes id_dst
  br_taken     in   1   branch resolved taken this cycle
  mem_busy     in   1   data memory not ready; freeze pipe
  pc_write     out  1   PC write enable
  ifid_write   out  1   IF/ID write enable
  ifid_flush   out  1   clear IF/ID to NOP
  idex_bubble  out  1   select zero control into ID/EX
  stall_count  out  CW  saturating count of load-use stall cycles

Function
REQ-003 The block SHALL hold a LOAD_LAT-deep scoreboard; each entry is {valid, dst[AW-1:0]}.
REQ-004 Entry k SHALL mean: a load issued k+1 cycles ago whose result a consumer in ID cannot yet use.
REQ-005 An ID instruction SHALL be an issuing load when id_valid, id_memread, id_regwrite and id_dst!=0 are all 1.
REQ-006 hazard SHALL be 1 when id_valid=1 and either of these holds against any valid entry:
  - id_uses_rs=1, id_rs!=0 and id_rs==entry.dst
  - id_uses_rt=1, id_rt!=0 and id_rt==entry.dst
REQ-007 Register 0 SHALL never cause a hazard.
REQ-008 Output priority SHALL be, highest first:
  - freeze (mem_busy=1)
  - flush (br_taken=1)
  - stall (hazard=1)
  - normal
REQ-009 Freeze outputs SHALL be pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=0; the scoreboard and stall_count SHALL hold.
REQ-010 br_taken SHALL be ignored while mem_busy=1; the source holds it until the freeze ends.
REQ-011 Flush outputs SHALL be pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1; the scoreboard SHALL shift in an invalid entry 0.
REQ-012 Stall outputs SHALL be pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=1; the scoreboard SHALL shift in an invalid entry 0 and stall_count SHALL increment.
REQ-013 Normal outputs SHALL be pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0; the scoreboard SHALL shift in {issuing load, id_dst}.
REQ-014 On every non-freeze cycle, entry LOAD_LAT-1 SHALL retire (be discarded).
REQ-015 The four control outputs SHALL be combinational from the current inputs and the registered scoreboard, with zero-cycle latency.
REQ-016 stall_count SHALL saturate at 2^CW-1 and never wrap.
REQ-017 A load that is itself stalled or flushed SHALL NOT enter the scoreboard.
REQ-018 With LOAD_LAT=1, a dependent instruction immediately after a load SHALL stall exactly 1 cycle.
REQ-019 In general, a consumer k instructions (k=1..LOAD_LAT) behind its load SHALL stall LOAD_LAT-k+1 cycles.

Reset
REQ-020 While reset=1 the scoreboard SHALL be all invalid (dst=0).
REQ-021 While reset=1 outputs SHALL be pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=1, stall_count=0, regardless of other inputs.
REQ-022 Reset SHALL take effect asynchronously, including mid-stall or mid-freeze; pending loads are discarded.
REQ-023 The first rising clock edge after reset deasserts SHALL see normal operation.

Structure
REQ-024 Shared package hazard_pkg SHALL hold:
  - the ZERO_REG constant
  - the MAX_LOAD_LAT=4 constant
  - the scoreboard-entry struct typedef
  - the output-mode enum {NORMAL, STALL, FLUSH, FREEZE}
REQ-025 Sub-module load_scoreboard SHALL implement the shift array (shift enable, insert valid/dst, per-entry match outputs for rs and rt); pipe_hazard_ctrl SHALL own the priority logic and stall_count.
REQ-026 Elaboration SHALL fail when LOAD_LAT<1 or LOAD_LAT>MAX_LOAD_LAT.

Verification
REQ-027 LOAD_LAT=1: lw $8 then add $9,$8,$8 -> one cycle of pc_write=0, idex_bubble=1; stall_count 0->1.
REQ-028 LOAD_LAT=3: lw $5, then add uses $5 at distance 1 / 2 / 3 -> 3 / 2 / 1 stall cycles respectively.
REQ-029 lw $0 followed by a $0 consumer, or lw $7 followed by a consumer with id_uses_rs=id_uses_rt=0 -> no stall.
REQ-030 Hazard and br_taken in the same cycle -> ifid_flush=1, pc_write=1, no count increment; the flushed load does not enter the scoreboard.
REQ-031 mem_busy=1 for 4 cycles during a pending load -> outputs frozen, scoreboard unchanged; the stall resumes afterward with the same remaining cycles.
REQ-032 CW=2 with 5 consecutive stalls -> stall_count=3; reset asserted mid-stall -> scoreboard cleared and stall_count=0 immediately.
